// File: rtl/ghost_hit_detector.sv
// rtl/ghost_hit_detector.sv - per-frame ghost/wall overlap detector with edge classification
module ghost_hit_detector #(
  parameter int OBJECT_WIDTH_X = 64,
  parameter int OBJECT_HIGHT_Y = 64,
  parameter int EDGE_MARGIN    = 4,
  parameter int MIN_HIT_PIXELS = 2,
  parameter int REPORT_DELAY   = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic        ghostDrawingRequest,
  input  logic        wallDrawingRequest,
  output logic        collision,
  output logic [3:0]  HitEdgeCode
);

  localparam logic signed [11:0] W12   = 12'(OBJECT_WIDTH_X);
  localparam logic signed [11:0] H12   = 12'(OBJECT_HIGHT_Y);
  localparam logic signed [11:0] M12   = 12'(EDGE_MARGIN);
  localparam logic signed [11:0] R12   = 12'(OBJECT_WIDTH_X - EDGE_MARGIN);
  localparam logic signed [11:0] B12   = 12'(OBJECT_HIGHT_Y - EDGE_MARGIN);
  localparam logic [11:0]        MIN12 = 12'(MIN_HIT_PIXELS);
  localparam int                 DW    = (REPORT_DELAY < 2) ? 1 : $clog2(REPORT_DELAY);
  localparam logic [DW-1:0]      DLY_LOAD = DW'(REPORT_DELAY - 1);

  typedef enum logic [1:0] {
    COLLECT_ST = 2'd0,
    DELAY_ST   = 2'd1,
    REPORT_ST  = 2'd2
  } state_t;

  state_t          state, next_state;
  logic signed [11:0] off_x, off_y;
  logic            in_range, valid_hit;
  logic [3:0]      edge_flags;
  logic [3:0]      acc_edge, acc_edge_now, snap_edge, snap_edge_next;
  logic [11:0]     acc_cnt, acc_cnt_now, snap_cnt, snap_cnt_next;
  logic [DW-1:0]   delay_cnt;
  logic            collision_next;

  // Pixel offset inside the sprite; topLeft may be negative when partly off-screen.
  assign off_x = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
  assign off_y = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});

  assign in_range   = !off_x[11] && (off_x < W12) && !off_y[11] && (off_y < H12);
  assign edge_flags = {off_x < M12, off_y < M12, off_x >= R12, off_y >= B12};
  assign valid_hit  = ghostDrawingRequest && wallDrawingRequest && in_range
                      && (state != REPORT_ST);

  assign acc_edge_now = acc_edge | (valid_hit ? edge_flags : 4'b0000);
  assign acc_cnt_now  = (valid_hit && (acc_cnt != 12'hFFF)) ? acc_cnt + 12'd1 : acc_cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      state <= COLLECT_ST;
    else if (reset)
      state <= COLLECT_ST;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      COLLECT_ST, REPORT_ST: begin
        if (startOfFrame)
          next_state = (REPORT_DELAY == 1) ? REPORT_ST : DELAY_ST;
        else
          next_state = COLLECT_ST;
      end
      DELAY_ST: begin
        if (startOfFrame)
          next_state = (REPORT_DELAY == 1) ? REPORT_ST : DELAY_ST;
        else if (delay_cnt == DW'(1))
          next_state = REPORT_ST;
      end
      default: next_state = COLLECT_ST;
    endcase
  end

  // The report decision uses the snapshot as it will be after this edge,
  // so a frame start that goes straight to REPORT_ST reports its own snapshot.
  always_comb begin
    snap_edge_next = snap_edge;
    snap_cnt_next  = snap_cnt;
    if (startOfFrame) begin
      snap_edge_next = acc_edge_now;
      snap_cnt_next  = acc_cnt_now;
    end
    collision_next = (next_state == REPORT_ST) && (snap_cnt_next >= MIN12);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc_edge    <= '0;
      acc_cnt     <= '0;
      snap_edge   <= '0;
      snap_cnt    <= '0;
      delay_cnt   <= '0;
      collision   <= 1'b0;
      HitEdgeCode <= '0;
    end else if (reset) begin
      acc_edge    <= '0;
      acc_cnt     <= '0;
      snap_edge   <= '0;
      snap_cnt    <= '0;
      delay_cnt   <= '0;
      collision   <= 1'b0;
      HitEdgeCode <= '0;
    end else begin
      snap_edge <= snap_edge_next;
      snap_cnt  <= snap_cnt_next;
      if (startOfFrame) begin
        acc_edge  <= '0;
        acc_cnt   <= '0;
        delay_cnt <= DLY_LOAD;
      end else begin
        acc_edge <= acc_edge_now;
        acc_cnt  <= acc_cnt_now;
        if (state == DELAY_ST)
          delay_cnt <= delay_cnt - DW'(1);
      end
      collision <= collision_next;
      if (collision_next)
        HitEdgeCode <= snap_edge_next;
    end
  end

endmodule

// File: tb/tb_ghost_hit_detector.sv
// tb/tb_ghost_hit_detector.sv - bench for ghost_hit_detector with report delays 3 and 5
module tb_ghost_hit_detector;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] pixelX = '0, pixelY = '0, topLeftX = '0, topLeftY = '0;
  logic        ghostDrawingRequest = 1'b0, wallDrawingRequest = 1'b0;
  logic        col3, col5;
  logic [3:0]  code3, code5;

  always #5 clk = ~clk;

  ghost_hit_detector u_d3 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .reset(reset),
    .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .ghostDrawingRequest(ghostDrawingRequest), .wallDrawingRequest(wallDrawingRequest),
    .collision(col3), .HitEdgeCode(code3)
  );

  ghost_hit_detector #(.REPORT_DELAY(5)) u_d5 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .reset(reset),
    .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .ghostDrawingRequest(ghostDrawingRequest), .wallDrawingRequest(wallDrawingRequest),
    .collision(col5), .HitEdgeCode(code5)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0, sof_cyc = 0;
  int dly[2] = '{3, 5};
  int m_cnt[2] = '{-1, -1};
  int m_acc_c[2] = '{0, 0};
  int m_snap_c[2] = '{0, 0};
  logic [3:0] m_acc_e[2] = '{4'd0, 4'd0};
  logic [3:0] m_snap_e[2] = '{4'd0, 4'd0};
  logic [3:0] m_code[2] = '{4'd0, 4'd0};
  logic m_col[2] = '{1'b0, 1'b0};
  int pulses[2] = '{0, 0};
  int pulse_cyc[2] = '{0, 0};

  // Reference: frame-window hit sets, a countdown to the report cycle (0 = report now).
  task automatic model_step();
    int ox, oy, ac;
    logic v;
    logic [3:0] ae;
    ox = int'(pixelX) - int'($signed(topLeftX));
    oy = int'(pixelY) - int'($signed(topLeftY));
    for (int i = 0; i < 2; i++) begin
      if (!resetN || reset) begin
        m_acc_e[i] = 0; m_acc_c[i] = 0; m_snap_e[i] = 0; m_snap_c[i] = 0;
        m_cnt[i] = -1; m_col[i] = 0; m_code[i] = 0;
      end else begin
        v = ghostDrawingRequest && wallDrawingRequest && ox >= 0 && ox < 64
            && oy >= 0 && oy < 64 && m_cnt[i] != 0;
        ae = m_acc_e[i];
        ac = m_acc_c[i];
        if (v) begin
          ae = ae | {ox < 4, oy < 4, ox >= 60, oy >= 60};
          if (ac < 4095) ac = ac + 1;
        end
        if (startOfFrame) begin
          m_snap_e[i] = ae; m_snap_c[i] = ac;
          m_acc_e[i] = 0; m_acc_c[i] = 0;
          m_cnt[i] = dly[i] - 1;
        end else begin
          m_acc_e[i] = ae; m_acc_c[i] = ac;
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : -1;
        end
        m_col[i] = 0;
        if (m_cnt[i] == 0 && m_snap_c[i] >= 2) begin
          m_col[i] = 1;
          m_code[i] = m_snap_e[i];
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      model_step();
    end
  end

  initial begin
    logic ac;
    logic [3:0] acode;
    logic ec;
    logic [3:0] ecode;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        ac    = (i == 0) ? col3 : col5;
        acode = (i == 0) ? code3 : code5;
        ec    = resetN ? m_col[i] : 1'b0;
        ecode = resetN ? m_code[i] : 4'd0;
        vectors = vectors + 1;
        if (ac !== ec || acode !== ecode) begin
          miscompares = miscompares + 1;
          $display("FAIL cycle%0d dut_d%0d: collision/code got %0b/%b expected %0b/%b",
                   cyc, dly[i], ac, acode, ec, ecode);
        end
        if (ac) begin
          pulses[i] = pulses[i] + 1;
          pulse_cyc[i] = cyc;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic g, input logic w, input int px,
                       input int py, input logic r, input logic rn);
    @(posedge clk);
    #1;
    resetN = rn;
    reset = r;
    startOfFrame = s;
    ghostDrawingRequest = g;
    wallDrawingRequest = w && (m_cnt[0] != 0) && (m_cnt[1] != 0);
    pixelX = 11'(px);
    pixelY = 11'(py);
    if (s) sof_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic hit(input int px, input int py);
    drive(1'b0, 1'b1, 1'b1, px, py, 1'b0, 1'b1);
  endtask

  task automatic sof();
    drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    int b0, b1, s, tx, ty, px, py;
    topLeftX = 11'(100);
    topLeftY = 11'(100);

    repeat (3) drive(1'b0, 1'b1, 1'b1, 130, 100, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    check("reset collision", int'(col3), 0);
    check("reset code d3", int'(code3), 0);
    check("reset code d5", int'(code5), 0);
    b0 = pulses[0];
    sof();
    idle(8);
    check("reset no pulse", pulses[0] - b0, 0);

    b0 = pulses[0]; b1 = pulses[1];
    hit(130, 100); hit(131, 101);
    sof(); s = sof_cyc;
    idle(8);
    check("top pulses d3", pulses[0] - b0, 1);
    check("top pulses d5", pulses[1] - b1, 1);
    check("top code d3", int'(code3), 4);
    check("top code d5", int'(code5), 4);
    check("top latency d3", pulse_cyc[0] - s, 3);
    check("top latency d5", pulse_cyc[1] - s, 5);
    check("top model code", int'(m_code[0]), 4);

    b0 = pulses[0];
    hit(100, 163); hit(101, 162);
    sof(); idle(8);
    check("corner pulses", pulses[0] - b0, 1);
    check("corner code", int'(code3), 9);

    b0 = pulses[0];
    hit(132, 132);
    sof(); idle(8);
    check("single hit no pulse", pulses[0] - b0, 0);
    check("single hit code held", int'(code3), 9);

    b0 = pulses[0];
    hit(132, 132); hit(132, 133); hit(132, 134);
    sof(); idle(8);
    check("centre pulses", pulses[0] - b0, 1);
    check("centre code", int'(code3), 0);

    b0 = pulses[0]; b1 = pulses[1];
    hit(100, 130); hit(100, 131);
    sof();
    hit(163, 130);
    drive(1'b1, 1'b1, 1'b1, 162, 131, 1'b0, 1'b1);
    s = sof_cyc;
    idle(8);
    check("resof pulses d5", pulses[1] - b1, 1);
    check("resof code d5", int'(code5), 2);
    check("resof latency d5", pulse_cyc[1] - s, 5);
    check("resof pulses d3", pulses[0] - b0, 1);
    check("resof code d3", int'(code3), 2);

    b0 = pulses[0]; b1 = pulses[1];
    hit(130, 100); hit(131, 100);
    sof();
    drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    idle(8);
    check("sync reset no pulse d3", pulses[0] - b0, 0);
    check("sync reset no pulse d5", pulses[1] - b1, 0);
    check("sync reset code d3", int'(code3), 0);
    check("sync reset code d5", int'(code5), 0);

    b0 = pulses[0];
    topLeftX = 11'(-10);
    hit(0, 130); hit(0, 131);
    sof(); idle(8);
    check("neg topleft pulses", pulses[0] - b0, 1);
    check("neg topleft code", int'(code3), 0);

    b0 = pulses[0];
    topLeftX = 11'(100);
    hit(200, 130); hit(200, 131); hit(200, 132);
    sof(); idle(8);
    check("out of box no pulse", pulses[0] - b0, 0);

    b0 = pulses[0];
    repeat (5000) hit(100, 100);
    sof(); idle(8);
    check("saturate pulses", pulses[0] - b0, 1);
    check("saturate code", int'(code3), 12);

    tx = 0; ty = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 64 == 0) begin
        tx = int'($urandom_range(0, 60)) - 10;
        ty = int'($urandom_range(0, 60)) - 10;
        topLeftX = 11'(tx);
        topLeftY = 11'(ty);
      end
      px = tx + int'($urandom_range(0, 80)) - 8;
      py = ty + int'($urandom_range(0, 80)) - 8;
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      drive(1'($urandom_range(0, 8) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), px, py, 1'($urandom_range(0, 249) == 0),
            1'($urandom_range(0, 599) != 0));
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
